// File: rtl/age_issue_queue.sv
// Out-of-order issue queue: holds dispatched ops until operands and FU are ready,
// then issues the oldest eligible entry, tracked by an age matrix.
module age_issue_queue #(
  parameter int DEPTH     = 8,
  parameter int PAYLOAD_W = 128,
  parameter int PREG_W    = 7,
  parameter int ROB_W     = 3,
  parameter int FU_W      = 3,
  parameter int NUM_WAKE  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PAYLOAD_W-1:0]         in_payload,
  input  logic [PREG_W-1:0]            in_rs1,
  input  logic [PREG_W-1:0]            in_rs2,
  input  logic                         in_rs1_rdy,
  input  logic                         in_rs2_rdy,
  input  logic [FU_W-1:0]              in_fu_sel,
  input  logic [ROB_W-1:0]             in_rob_idx,
  input  logic [NUM_WAKE-1:0]          wk_valid,
  input  logic [NUM_WAKE*PREG_W-1:0]   wk_tag,
  input  logic [2**FU_W-1:0]           fu_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PAYLOAD_W-1:0]         out_payload,
  output logic [PREG_W-1:0]            out_rs1,
  output logic [PREG_W-1:0]            out_rs2,
  output logic [FU_W-1:0]              out_fu_sel,
  output logic [ROB_W-1:0]             out_rob_idx,
  input  logic                         flush,
  input  logic [2**ROB_W-1:0]          flush_mask,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  // Tag 0 is the hardwired-ready register, so it never counts as a broadcast hit.
  function automatic logic wake_hit(input logic [PREG_W-1:0] tag,
                                    input logic [NUM_WAKE-1:0] wv,
                                    input logic [NUM_WAKE*PREG_W-1:0] wt);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_WAKE; k++)
      if (wv[k] && wt[k*PREG_W +: PREG_W] == tag && tag != '0) hit = 1'b1;
    return hit;
  endfunction

  logic [DEPTH-1:0]     valid_reg, rs1_rdy_reg, rs2_rdy_reg;
  logic [DEPTH-1:0]     age_reg [DEPTH];
  logic [CNT_W-1:0]     count_reg;
  logic [PAYLOAD_W-1:0] payload_mem [DEPTH];
  logic [PREG_W-1:0]    rs1_mem [DEPTH];
  logic [PREG_W-1:0]    rs2_mem [DEPTH];
  logic [FU_W-1:0]      fu_sel_mem [DEPTH];
  logic [ROB_W-1:0]     rob_idx_mem [DEPTH];

  logic [DEPTH-1:0] rs1_hit, rs2_hit, kill, elig, sel;
  logic [DEPTH-1:0] valid_next;
  logic [CNT_W-1:0] count_next;
  logic [IDX_W-1:0] sel_idx, alloc_idx;
  logic             dispatch_fire, issue_fire, in_op1_rdy, in_op2_rdy;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic             op1_rdy, op2_rdy;
      logic [DEPTH-1:0] older_elig;
      assign rs1_hit[gi] = wake_hit(rs1_mem[gi], wk_valid, wk_tag);
      assign rs2_hit[gi] = wake_hit(rs2_mem[gi], wk_valid, wk_tag);
      assign op1_rdy     = rs1_rdy_reg[gi] | rs1_hit[gi] | (rs1_mem[gi] == '0);
      assign op2_rdy     = rs2_rdy_reg[gi] | rs2_hit[gi] | (rs2_mem[gi] == '0);
      assign kill[gi]    = flush & flush_mask[rob_idx_mem[gi]];
      // A killed entry must not be offered for issue in the flush cycle.
      assign elig[gi]    = valid_reg[gi] & ~kill[gi] & op1_rdy & op2_rdy &
                           fu_ready[fu_sel_mem[gi]];
      for (genvar gj = 0; gj < DEPTH; gj++) begin : g_col
        assign older_elig[gj] = elig[gj] & age_reg[gj][gi];
      end
      assign sel[gi] = elig[gi] & ~(|older_elig);
    end
  endgenerate

  always_comb begin
    sel_idx   = '0;
    alloc_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (sel[i]) sel_idx = IDX_W'(i);
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!valid_reg[i]) alloc_idx = IDX_W'(i);
  end

  assign in_ready      = (count_reg < CNT_W'(DEPTH));
  assign out_valid     = |elig;
  assign issue_fire    = out_valid & out_ready;
  assign dispatch_fire = in_valid & in_ready & ~(flush & flush_mask[in_rob_idx]);
  assign in_op1_rdy    = in_rs1_rdy | wake_hit(in_rs1, wk_valid, wk_tag) | (in_rs1 == '0);
  assign in_op2_rdy    = in_rs2_rdy | wake_hit(in_rs2, wk_valid, wk_tag) | (in_rs2 == '0);

  assign out_payload = payload_mem[sel_idx];
  assign out_rs1     = rs1_mem[sel_idx];
  assign out_rs2     = rs2_mem[sel_idx];
  assign out_fu_sel  = fu_sel_mem[sel_idx];
  assign out_rob_idx = rob_idx_mem[sel_idx];
  assign count       = count_reg;

  always_comb begin
    valid_next = valid_reg & ~kill;
    if (issue_fire) valid_next = valid_next & ~sel;
    if (dispatch_fire) valid_next[alloc_idx] = 1'b1;
    count_next = '0;
    for (int i = 0; i < DEPTH; i++)
      count_next = count_next + CNT_W'(valid_next[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg   <= '0;
      rs1_rdy_reg <= '0;
      rs2_rdy_reg <= '0;
      count_reg   <= '0;
      for (int i = 0; i < DEPTH; i++) age_reg[i] <= '0;
    end else begin
      valid_reg   <= valid_next;
      count_reg   <= count_next;
      rs1_rdy_reg <= rs1_rdy_reg | rs1_hit;
      rs2_rdy_reg <= rs2_rdy_reg | rs2_hit;
      if (dispatch_fire) begin
        rs1_rdy_reg[alloc_idx] <= in_op1_rdy;
        rs2_rdy_reg[alloc_idx] <= in_op2_rdy;
        // Newcomer is younger than every entry currently resident.
        age_reg[alloc_idx] <= '0;
        for (int i = 0; i < DEPTH; i++) age_reg[i][alloc_idx] <= valid_reg[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (dispatch_fire) begin
      payload_mem[alloc_idx] <= in_payload;
      rs1_mem[alloc_idx]     <= in_rs1;
      rs2_mem[alloc_idx]     <= in_rs2;
      fu_sel_mem[alloc_idx]  <= in_fu_sel;
      rob_idx_mem[alloc_idx] <= in_rob_idx;
    end
  end

endmodule

// File: tb/tb_age_issue_queue.sv
// Directed bench for age_issue_queue: ordering, wakeup, full/backpressure,
// flush, FU busy and reset behaviour.
module tb_age_issue_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_payload;
  logic [6:0]   in_rs1, in_rs2;
  logic         in_rs1_rdy, in_rs2_rdy;
  logic [2:0]   in_fu_sel, in_rob_idx;
  logic [1:0]   wk_valid;
  logic [13:0]  wk_tag;
  logic [7:0]   fu_ready;
  logic         out_valid, out_ready;
  logic [127:0] out_payload;
  logic [6:0]   out_rs1, out_rs2;
  logic [2:0]   out_fu_sel, out_rob_idx;
  logic         flush;
  logic [7:0]   flush_mask;
  logic [3:0]   count;

  int total = 0;
  int bad   = 0;

  always #10 clk = ~clk;

  age_issue_queue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_rdy(in_rs1_rdy), .in_rs2_rdy(in_rs2_rdy),
    .in_fu_sel(in_fu_sel), .in_rob_idx(in_rob_idx),
    .wk_valid(wk_valid), .wk_tag(wk_tag), .fu_ready(fu_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_fu_sel(out_fu_sel), .out_rob_idx(out_rob_idx),
    .flush(flush), .flush_mask(flush_mask), .count(count)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [2:0] rob, input logic [6:0] rs1, input logic r1,
                          input logic [6:0] rs2, input logic r2, input logic [2:0] fu,
                          input logic [127:0] pl);
    in_rob_idx = rob; in_rs1 = rs1; in_rs1_rdy = r1; in_rs2 = rs2; in_rs2_rdy = r2;
    in_fu_sel = fu; in_payload = pl; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    $display("dispatch rob=%0d rs1=%0d/%0b rs2=%0d/%0b fu=%0d payload=%0h count=%0d",
             rob, rs1, r1, rs2, r2, fu, pl, count);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_payload = '0; in_rs1 = '0; in_rs2 = '0;
    in_rs1_rdy = 1'b0; in_rs2_rdy = 1'b0; in_fu_sel = '0; in_rob_idx = '0;
    wk_valid = '0; wk_tag = '0; fu_ready = 8'hFF; out_ready = 1'b0;
    flush = 1'b0; flush_mask = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);

    // In-order issue of two ready ops
    dispatch(3'd1, 7'd1, 1'b1, 7'd2, 1'b1, 3'd0, 128'hA);
    check("ab_count1", count, 1);
    check("ab_lat1_valid", out_valid, 1);
    dispatch(3'd2, 7'd3, 1'b1, 7'd4, 1'b1, 3'd0, 128'hB);
    check("ab_count2", count, 2);
    out_ready = 1'b1; #1;
    check("ab_first_rob", out_rob_idx, 1);
    check("ab_first_payload", out_payload, 128'hA);
    tick();
    check("ab_count_after1", count, 1);
    check("ab_second_rob", out_rob_idx, 2);
    tick();
    check("ab_count_after2", count, 0);
    check("ab_empty_valid", out_valid, 0);

    // Younger ready op bypasses older waiting op; wakeup releases it
    out_ready = 1'b0;
    dispatch(3'd1, 7'd5, 1'b0, 7'd0, 1'b0, 3'd0, 128'hC);
    dispatch(3'd2, 7'd6, 1'b1, 7'd7, 1'b1, 3'd0, 128'hD);
    check("wk_first_rob", out_rob_idx, 2);
    out_ready = 1'b1; #1;
    tick();
    out_ready = 1'b0; #1;
    check("wk_count1", count, 1);
    check("wk_blocked", out_valid, 0);
    wk_valid = 2'b01; wk_tag = {7'd0, 7'd5}; #1;
    check("wk_same_cycle_valid", out_valid, 1);
    check("wk_same_cycle_rob", out_rob_idx, 1);
    tick();
    wk_valid = 2'b00; wk_tag = '0; #1;
    check("wk_stored_valid", out_valid, 1);
    out_ready = 1'b1; #1;
    tick();
    check("wk_count0", count, 0);

    // Fill, then simultaneous issue with held dispatch
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++)
      dispatch(3'(k), 7'd1, 1'b1, 7'd2, 1'b1, 3'd0, 128'(k));
    check("full_count", count, 8);
    check("full_in_ready", in_ready, 0);
    in_rob_idx = 3'd0; in_payload = 128'h99; in_valid = 1'b1; out_ready = 1'b1; #1;
    check("full_oldest", out_payload, 0);
    tick();
    check("full_issue_only_count", count, 7);
    check("full_in_ready_after", in_ready, 1);
    out_ready = 1'b0; #1;
    tick();
    in_valid = 1'b0;
    check("full_refill_count", count, 8);
    out_ready = 1'b1; #1;
    for (int k = 1; k < 8; k++) begin
      check("drain_order", out_payload, 128'(k));
      tick();
    end
    check("drain_last", out_payload, 128'h99);
    tick();
    check("drain_count", count, 0);

    // Flush kills rob 3,4 and drops a same-cycle rob-3 dispatch
    out_ready = 1'b0;
    dispatch(3'd2, 7'd1, 1'b1, 7'd2, 1'b1, 3'd0, 128'h20);
    dispatch(3'd3, 7'd1, 1'b1, 7'd2, 1'b1, 3'd0, 128'h30);
    dispatch(3'd4, 7'd1, 1'b1, 7'd2, 1'b1, 3'd0, 128'h40);
    flush = 1'b1; flush_mask = 8'h18;
    in_rob_idx = 3'd3; in_payload = 128'h33; in_valid = 1'b1; #1;
    check("flush_sel_rob", out_rob_idx, 2);
    tick();
    flush = 1'b0; flush_mask = '0; in_valid = 1'b0; #1;
    check("flush_count", count, 1);
    check("flush_remain_rob", out_rob_idx, 2);
    out_ready = 1'b1; #1;
    tick();
    check("flush_drained", count, 0);
    check("flush_dropped", out_valid, 0);

    // Busy FU on oldest lets younger op on other FU go first
    out_ready = 1'b0; fu_ready = 8'hFB;
    dispatch(3'd1, 7'd1, 1'b1, 7'd2, 1'b1, 3'd2, 128'h50);
    dispatch(3'd2, 7'd1, 1'b1, 7'd2, 1'b1, 3'd5, 128'h60);
    check("fu_young_rob", out_rob_idx, 2);
    check("fu_young_sel", out_fu_sel, 5);
    out_ready = 1'b1; #1;
    tick();
    check("fu_old_blocked", out_valid, 0);
    fu_ready = 8'hFF; #1;
    check("fu_old_rob", out_rob_idx, 1);
    tick();
    check("fu_count0", count, 0);

    // Reset with queue occupied
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      dispatch(3'(k), 7'd1, 1'b1, 7'd2, 1'b1, 3'd0, 128'(k + 16));
    check("prerst_count", count, 5);
    check("prerst_valid", out_valid, 1);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; #1;
    check("postrst_count", count, 0);
    check("postrst_valid", out_valid, 0);
    check("postrst_in_ready", in_ready, 1);
    tick();
    check("postrst_idle_count", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/age_issue_queue.md
AGE_ISSUE_QUEUE -- requirements
Module: age_issue_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, the number of queue entries (range 2..16).
REQ-002 The block SHALL have parameter PAYLOAD_W, default 128, the opaque payload width (pc/inst/imm/op/f3/f7/rd/ld/st/jump).
REQ-003 The block SHALL have parameter PREG_W, default 7, the physical register tag width.
REQ-004 The block SHALL have parameter ROB_W, default 3, the ROB index width.
REQ-005 The block SHALL have parameter FU_W, default 3, the functional-unit select width.
REQ-006 The block SHALL have parameter NUM_WAKE, default 2, the number of wakeup broadcast ports.
REQ-007 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-008 Port rst, input, 1: reset, synchronous and active-high.
REQ-009 Port in_valid / in_ready, input / output, 1 / 1: dispatch handshake.
REQ-010 Port in_payload, input, PAYLOAD_W: the dispatched payload.
REQ-011 Port in_rs1 / in_rs2, input, PREG_W each: the source tags.
REQ-012 Port in_rs1_rdy / in_rs2_rdy, input, 1 each: the source ready bits from rename.
REQ-013 Port in_fu_sel / in_rob_idx, input, FU_W / ROB_W: the FU select and ROB index.
REQ-014 Port wk_valid, input, NUM_WAKE: per-port wakeup valid.
REQ-015 Port wk_tag, input, NUM_WAKE*PREG_W: per-port wakeup tags; port k occupies bits [k*PREG_W +: PREG_W].
REQ-016 Port fu_ready, input, 2**FU_W: per-FU accept-ready.
REQ-017 Port out_valid / out_ready, output / input, 1 / 1: issue handshake.
REQ-018 Port out_payload, out_rs1, out_rs2, out_fu_sel, out_rob_idx, output: the selected entry's fields.
REQ-019 Port flush / flush_mask, input, 1 / 2**ROB_W: mispredict squash; mask bit set means kill that ROB index.
REQ-020 Port count, output, $clog2(DEPTH+1): the number of valid entries (registered).

Function
REQ-021 Each entry SHALL hold: valid, payload, rs1, rs2, rs1_rdy, rs2_rdy, fu_sel, rob_idx; an age matrix age[i][j]=1 SHALL mean entry i is older than entry j.
REQ-022 in_ready SHALL be (count < DEPTH), from registered state only; entries freed in the same cycle are not reusable that cycle.
REQ-023 Dispatch (in_valid && in_ready) SHALL write the lowest-index free entry; the new entry's age row is set to 0, and its column is set to 1 in all currently valid rows.
REQ-024 An operand SHALL be ready if its stored rdy bit is set, or its tag matches any wk_valid port this cycle, or its tag is 0; the same rule SHALL apply to in_rs* at dispatch capture.
REQ-025 Wakeup SHALL set the stored rdy bits of all valid entries with a matching tag at the clock edge (tag 0 is ignored as a broadcast).
REQ-026 An entry SHALL be eligible when valid, both operands ready (REQ-024), and fu_ready[fu_sel]=1.
REQ-027 Select SHALL choose the eligible entry i with no eligible j where age[j][i]=1 (oldest-first); out_valid SHALL be 1 iff any entry is eligible.
REQ-028 Select and the out_* fields SHALL be combinational; outputs are don't-care when out_valid=0.
REQ-029 When out_valid && out_ready, the selected entry SHALL be invalidated at the edge, and its row and column are don't-care thereafter.
REQ-030 Minimum latency from dispatch to out_valid SHALL be 1 cycle, and a same-cycle wakeup SHALL enable issue in that cycle.
REQ-031 On flush, every entry with flush_mask[rob_idx]=1 SHALL be invalidated; flush SHALL override issue and wakeup for killed entries.
REQ-032 A dispatch coinciding with flush SHALL be dropped if flush_mask[in_rob_idx]=1, and written otherwise.
REQ-033 count SHALL update as count + dispatched - issued - flushed, never exceeding DEPTH nor underflowing.
REQ-034 Simultaneous dispatch and issue when count=DEPTH SHALL issue only; count becomes DEPTH-1.

Reset
REQ-035 On rst=1 at the edge, all entries SHALL be invalid, the age matrix 0, and count=0; consequently in_ready=1 and out_valid=0 from the next cycle; rst SHALL override flush, dispatch and issue.

Verification
REQ-036 The bench SHALL cover: dispatch A(rob 1, tags ready), then B(rob 2, ready), with fu_ready all 1 and out_ready=1 -> A issues first, then B; count goes 1,2,1,0.
REQ-037 The bench SHALL cover: A dispatched with rs1=5 not ready, then B ready -> B issues first; a wakeup on tag 5 then issues A in the wakeup cycle.
REQ-038 The bench SHALL cover: filling 8 entries -> in_ready=0; issuing one with in_valid held -> the new entry is accepted next cycle, not the same cycle.
REQ-039 The bench SHALL cover: entries with rob 2,3,4 and flush with mask 0x18 -> only rob 2 remains (count=1), and a simultaneous dispatch of rob 3 is dropped.
REQ-040 The bench SHALL cover: the oldest entry's fu_ready=0 -> the younger eligible entry on another FU issues, and the oldest issues when its FU becomes ready.
REQ-041 The bench SHALL cover: rst asserted with 5 valid entries and out_valid=1 -> next cycle count=0, out_valid=0, in_ready=1.
